// File: rtl/irq_sel_mux_pkg.sv
// Shared types for the registered interrupt source selector.
// Holds the two-state controller encoding used by the top level.
package irq_sel_mux_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Bit offset of block k inside the packed input, where block 0 sits in the MSBs.
    function automatic int unsigned blk_lsb(input int unsigned dw, input int unsigned n,
                                            input int unsigned k);
        return dw * (n - 1 - k);
    endfunction

endpackage

// File: rtl/irq_sel_mux_if.sv
// Source/consumer bundle of the selector: packed blocks, request/mask vectors, grant outputs.
// master drives the sources and the ack; slave is the selector itself.
interface irq_sel_mux_if #(
    parameter int DW = 8,
    parameter int CW = 2
);
    localparam int N = 1 << CW;

    logic [DW*N-1:0] i;
    logic [N-1:0]    req;
    logic [N-1:0]    mask;
    logic            ack;
    logic [DW-1:0]   o;
    logic [CW-1:0]   s;
    logic            vld;
    logic            pend;

    modport master (
        output i, req, mask, ack,
        input  o, s, vld, pend
    );

    modport slave (
        input  i, req, mask, ack,
        output o, s, vld, pend
    );

endinterface

// File: rtl/irq_sel_mux_rr_pick.sv
// Combinational winner search: first set bit of eff scanning upward from p, wrapping mod N.
// Zero latency; any=0 means no eligible source and w is then meaningless.
module rr_pick #(
    parameter int N  = 4,
    parameter int CW = 2
) (
    input  logic [N-1:0]  eff,
    input  logic [CW-1:0] p,
    output logic [CW-1:0] w,
    output logic          any
);

    logic [N-1:0]  rot;
    logic [CW-1:0] idx;

    // Rotate right by p so the scan start lands on bit 0; CW-bit index math wraps mod N.
    always_comb begin
        rot = '0;
        for (int k = 0; k < N; k++) begin
            rot[k] = eff[CW'(k) + p];
        end
    end

    always_comb begin
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = CW'(k);
            end
        end
    end

    assign w   = idx + p;
    assign any = |eff;

endmodule

// File: rtl/irq_sel_mux.sv
// Registered arbiter: grants one unmasked requester, latches its block/index, holds until ack.
// Latency req->vld 1 cycle; holds indefinitely without ack, then one IDLE cycle before the next grant.
module irq_sel_mux
    import irq_sel_mux_pkg::*;
#(
    parameter int DW = 8,
    parameter int CW = 2,
    parameter int RR = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    irq_sel_mux_if.slave bus
);

    localparam int N = 1 << CW;

    state_e        state_q, state_d;
    logic [DW-1:0] o_q, o_d;
    logic [CW-1:0] s_q, s_d;
    logic [CW-1:0] p_q, p_d;
    logic          vld_q, vld_d;

    logic [N-1:0]  eff;
    logic [CW-1:0] pick_base;
    logic [CW-1:0] win;
    logic          any;
    logic [DW-1:0] sel_blk;

    assign eff       = bus.req & ~bus.mask;
    assign pick_base = (RR != 0) ? p_q : '0;

    rr_pick #(
        .N  (N),
        .CW (CW)
    ) u_pick (
        .eff (eff),
        .p   (pick_base),
        .w   (win),
        .any (any)
    );

    always_comb begin
        sel_blk = '0;
        for (int k = 0; k < N; k++) begin
            if (win == CW'(k)) begin
                sel_blk = bus.i[blk_lsb(DW, N, k) +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        o_d     = o_q;
        s_d     = s_q;
        p_d     = p_q;
        vld_d   = vld_q;
        case (state_q)
            ST_IDLE: begin
                vld_d = 1'b0;
                if (any) begin
                    o_d     = sel_blk;
                    s_d     = win;
                    vld_d   = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Inputs are ignored here; only ack releases the grant.
                if (bus.ack) begin
                    vld_d   = 1'b0;
                    state_d = ST_IDLE;
                    if (RR != 0) begin
                        p_d = s_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            o_q     <= '0;
            s_q     <= '0;
            p_q     <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            s_q     <= s_d;
            p_q     <= p_d;
            vld_q   <= vld_d;
        end
    end

    assign bus.o    = o_q;
    assign bus.s    = s_q;
    assign bus.vld  = vld_q;
    assign bus.pend = |eff;

endmodule

// File: tb/tb_irq_sel_mux.sv
// Bench for irq_sel_mux: fixed-priority and round-robin instances share one stimulus stream.
// A reference model queues each expected grant; a monitor pops and compares when vld rises.
module tb_irq_sel_mux;

    localparam int DW = 8;
    localparam int CW = 2;
    localparam int N  = 4;
    localparam logic [DW*N-1:0] I_DEF = {8'hA0, 8'hB1, 8'hC2, 8'hD3};

    typedef struct {
        logic [DW-1:0] o;
        int            s;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DW*N-1:0] i_v = I_DEF;
    logic [N-1:0]    req_v = '0;
    logic [N-1:0]    mask_v = '0;
    logic            ack_v = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    irq_sel_mux_if #(.DW(DW), .CW(CW)) bus0 ();
    irq_sel_mux_if #(.DW(DW), .CW(CW)) bus1 ();

    assign bus0.i = i_v;   assign bus0.req = req_v; assign bus0.mask = mask_v; assign bus0.ack = ack_v;
    assign bus1.i = i_v;   assign bus1.req = req_v; assign bus1.mask = mask_v; assign bus1.ack = ack_v;

    irq_sel_mux #(.DW(DW), .CW(CW), .RR(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    irq_sel_mux #(.DW(DW), .CW(CW), .RR(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic          vld_s  [2];
    logic          pend_s [2];
    logic [DW-1:0] o_s    [2];
    logic [CW-1:0] s_s    [2];
    assign vld_s[0] = bus0.vld;  assign pend_s[0] = bus0.pend;  assign o_s[0] = bus0.o;  assign s_s[0] = bus0.s;
    assign vld_s[1] = bus1.vld;  assign pend_s[1] = bus1.pend;  assign o_s[1] = bus1.o;  assign s_s[1] = bus1.s;

    // Reference model state
    bit            busy  [2];
    int            p_m   [2];
    int            cur_s [2];
    logic [DW-1:0] cur_o [2];
    exp_t          q0[$];
    exp_t          q1[$];
    int            log0[$];
    int            log1[$];
    bit            prev_vld [2];

    function automatic int pick(input logic [N-1:0] eff, input int base);
        for (int off = 0; off < N; off++) begin
            int k;
            k = (base + off) % N;
            if (eff[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [DW-1:0] blk(input logic [DW*N-1:0] v, input int k);
        logic [DW*N-1:0] t;
        t = v >> (DW * (N - 1 - k));
        return t[DW-1:0];
    endfunction

    task automatic chk(input string name, input int r, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d t=%0t actual=%0h required=%0h", name, r, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        logic [N-1:0] eff;
        int           w;
        exp_t         e;
        for (int r = 0; r < 2; r++) begin
            if (!rst_n) begin
                busy[r] = 1'b0; p_m[r] = 0; cur_s[r] = 0; cur_o[r] = '0;
            end else if (busy[r]) begin
                if (ack_v) begin
                    busy[r] = 1'b0;
                    if (r == 1) p_m[r] = (cur_s[r] + 1) % N;
                end
            end else begin
                eff = req_v & ~mask_v;
                w   = pick(eff, (r == 1) ? p_m[r] : 0);
                if (w >= 0) begin
                    busy[r]  = 1'b1;
                    cur_s[r] = w;
                    cur_o[r] = blk(i_v, w);
                    e.o = cur_o[r];
                    e.s = w;
                    if (r == 0) q0.push_back(e); else q1.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        for (int r = 0; r < 2; r++) begin
            chk("vld", r, 32'(vld_s[r]), 32'(busy[r]));
            chk("o_held", r, 32'(o_s[r]), 32'(cur_o[r]));
            chk("s_held", r, 32'(s_s[r]), 32'(cur_s[r]));
            chk("pend", r, 32'(pend_s[r]), 32'(|(req_v & ~mask_v)));
            if (vld_s[r] && !prev_vld[r]) begin
                if (r == 0) log0.push_back(int'(s_s[r])); else log1.push_back(int'(s_s[r]));
                if ((r == 0 && q0.size() == 0) || (r == 1 && q1.size() == 0)) begin
                    chk("unexpected_grant", r, 32'(1), 32'(0));
                end else begin
                    e = (r == 0) ? q0.pop_front() : q1.pop_front();
                    chk("grant_o", r, 32'(o_s[r]), 32'(e.o));
                    chk("grant_s", r, 32'(s_s[r]), 32'(e.s));
                end
            end
            prev_vld[r] = vld_s[r];
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int rr_seq [6];
        rr_seq = '{0, 1, 2, 3, 0, 1};

        // Reset with requests and ack asserted
        rst_n = 1'b0; req_v = 4'hF; ack_v = 1'b1;
        cyc(2);

        // Fixed priority pick, then hold against input changes
        rst_n = 1'b1; ack_v = 1'b0; req_v = 4'b0110;
        cyc(1);
        i_v = '0; req_v = '0;
        cyc(2);
        ack_v = 1'b1;
        cyc(1);
        ack_v = 1'b0; req_v = 4'b1000; i_v = I_DEF;
        cyc(3);
        ack_v = 1'b1; req_v = '0;
        cyc(2);

        // Round-robin wrap from a fresh pointer
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1; req_v = 4'hF; ack_v = 1'b1;
        log1.delete();
        cyc(12);
        for (int k = 0; k < 6; k++) begin
            if (k < log1.size()) chk("rr_sequence", 1, 32'(log1[k]), 32'(rr_seq[k]));
            else chk("rr_sequence_short", 1, 32'(log1.size()), 32'(6));
        end

        // Masked request: no pend, no grant; unmask releases it
        rst_n = 1'b0; req_v = '0; ack_v = 1'b0;
        cyc(1);
        rst_n = 1'b1; mask_v = 4'b0010; req_v = 4'b0010;
        cyc(3);
        mask_v = '0;
        cyc(2);
        ack_v = 1'b1; req_v = '0;
        cyc(2);

        // Reset mid-HOLD with round-robin pointer at 2
        rst_n = 1'b0;
        cyc(1);
        rst_n = 1'b1; req_v = 4'hF; ack_v = 1'b1;
        cyc(4);
        ack_v = 1'b0;
        cyc(1);
        rst_n = 1'b0;
        cyc(1);
        log1.delete();
        rst_n = 1'b1;
        cyc(2);
        if (log1.size() > 0) chk("rr_after_reset", 1, 32'(log1[0]), 32'(0));
        else chk("rr_after_reset_missing", 1, 32'(0), 32'(1));

        // Randomized traffic with occasional resets
        for (int c = 0; c < 3000; c++) begin
            req_v  = N'($urandom);
            mask_v = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            if ($urandom_range(0, 4) == 0) i_v = {$urandom};
            ack_v  = ($urandom_range(0, 2) == 0);
            rst_n  = ($urandom_range(0, 199) != 0);
            cyc(1);
        end

        rst_n = 1'b1; req_v = '0; ack_v = 1'b1;
        cyc(3);
        chk("queue_drained", 0, 32'(q0.size()), 32'(0));
        chk("queue_drained", 1, 32'(q1.size()), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
